// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM (one write port, one read port).
// Each port has its own round-robin pointer; same-edge write/read to one address bypasses the RAM.
module ram_arbiter #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [addr_width-1:0] ADDR0,
    input  logic [addr_width-1:0] ADDR1,
    input  logic [data_width-1:0] WDATA0,
    input  logic [data_width-1:0] WDATA1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  RVALID0,
    output logic                  RVALID1,
    output logic [data_width-1:0] RDATA0,
    output logic [data_width-1:0] RDATA1,
    output logic [addr_width-1:0] ADDR_W,
    output logic                  ENABLE_W,
    output logic [data_width-1:0] Q_W,
    output logic [addr_width-1:0] ADDR_R,
    input  logic [data_width-1:0] Q_R
);

    // Each pointer names the requester that wins the next contention on its port.
    logic ptr_w, ptr_r;
    logic wr0, wr1, rd0, rd1;
    logic gnt_w0, gnt_w1, gnt_r0, gnt_r1;
    logic [addr_width-1:0] addr_r_q;
    logic rvalid0_q, rvalid1_q, bypass_q;
    logic [data_width-1:0] bypass_data_q;

    always_comb begin
        wr0    = REQ0 & WE0 & ~RESET;
        wr1    = REQ1 & WE1 & ~RESET;
        rd0    = REQ0 & ~WE0 & ~RESET;
        rd1    = REQ1 & ~WE1 & ~RESET;
        gnt_w0 = wr0 & (~wr1 | ~ptr_w);
        gnt_w1 = wr1 & (~wr0 | ptr_w);
        gnt_r0 = rd0 & (~rd1 | ~ptr_r);
        gnt_r1 = rd1 & (~rd0 | ptr_r);
    end

    assign GNT0 = gnt_w0 | gnt_r0;
    assign GNT1 = gnt_w1 | gnt_r1;

    always_comb begin
        ENABLE_W = gnt_w0 | gnt_w1;
        ADDR_W   = '0;
        Q_W      = '0;
        ADDR_R   = addr_r_q;
        if (gnt_w0) begin
            ADDR_W = ADDR0;
            Q_W    = WDATA0;
        end else if (gnt_w1) begin
            ADDR_W = ADDR1;
            Q_W    = WDATA1;
        end
        if (gnt_r0) begin
            ADDR_R = ADDR0;
        end else if (gnt_r1) begin
            ADDR_R = ADDR1;
        end
    end

    // The RAM returns the pre-write contents on a same-edge collision, so the write data is kept aside.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_w         <= 1'b0;
            ptr_r         <= 1'b0;
            addr_r_q      <= '0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            bypass_q      <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            if (wr0 & wr1) begin
                ptr_w <= ~ptr_w;
            end
            if (rd0 & rd1) begin
                ptr_r <= ~ptr_r;
            end
            addr_r_q      <= ADDR_R;
            rvalid0_q     <= gnt_r0;
            rvalid1_q     <= gnt_r1;
            bypass_q      <= ENABLE_W & (gnt_r0 | gnt_r1) & (ADDR_W == ADDR_R);
            bypass_data_q <= Q_W;
        end
    end

    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign RDATA0  = rvalid0_q ? (bypass_q ? bypass_data_q : Q_R) : '0;
    assign RDATA1  = rvalid1_q ? (bypass_q ? bypass_data_q : Q_R) : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: attaches a behavioural RAM and compares every cycle against a
// transaction-level reference model (round-robin winners, memory array, pending read results).
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1, ENABLE_W;
    logic [DW-1:0] RDATA0, RDATA1, Q_W, Q_R;
    logic [AW-1:0] ADDR_W, ADDR_R;

    ram_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA0(RDATA0), .RDATA1(RDATA1),
        .ADDR_W(ADDR_W), .ENABLE_W(ENABLE_W), .Q_W(Q_W),
        .ADDR_R(ADDR_R), .Q_R(Q_R)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data shows up one cycle after the address, pre-write contents on collision.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (ENABLE_W) ram[ADDR_W] <= Q_W;
        Q_R <= ram[ADDR_R];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            prio_w, prio_r;
    logic [AW-1:0] last_raddr;
    logic          exp_rv [2];
    logic [DW-1:0] exp_rd [2];

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        prio_w     = 0;
        prio_r     = 0;
        last_raddr = '0;
        for (int i = 0; i < 2; i++) begin
            exp_rv[i] = 1'b0;
            exp_rd[i] = '0;
        end
    endtask

    // Entered and left at a falling edge: checks last cycle's read results, drives one request
    // pair, checks the combinational outputs, then advances the model across the rising edge.
    task automatic apply_stimulus(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                  input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                  output logic g0, output logic g1);
        int            wwin, rwin;
        logic [AW-1:0] waddr, raddr, exp_addr_r;
        logic [DW-1:0] wdata;
        logic [AW-1:0] addrs [2];
        logic [DW-1:0] datas [2];
        logic          wants_w [2];
        logic          wants_r [2];

        checks++;
        if (RVALID0 !== exp_rv[0] || RDATA0 !== exp_rd[0]) begin
            errors++;
            $display("[TB] FAIL read0: got valid=%b data=%h, expected valid=%b data=%h", RVALID0, RDATA0, exp_rv[0], exp_rd[0]);
        end
        checks++;
        if (RVALID1 !== exp_rv[1] || RDATA1 !== exp_rd[1]) begin
            errors++;
            $display("[TB] FAIL read1: got valid=%b data=%h, expected valid=%b data=%h", RVALID1, RDATA1, exp_rv[1], exp_rd[1]);
        end

        REQ0 = r0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
        REQ1 = r1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
        #1;

        addrs[0] = a0; addrs[1] = a1;
        datas[0] = d0; datas[1] = d1;
        wants_w[0] = r0 && w0;  wants_w[1] = r1 && w1;
        wants_r[0] = r0 && !w0; wants_r[1] = r1 && !w1;

        wwin = -1;
        if (wants_w[0] && wants_w[1]) wwin = prio_w;
        else if (wants_w[0])          wwin = 0;
        else if (wants_w[1])          wwin = 1;
        rwin = -1;
        if (wants_r[0] && wants_r[1]) rwin = prio_r;
        else if (wants_r[0])          rwin = 0;
        else if (wants_r[1])          rwin = 1;

        g0 = (wwin == 0) || (rwin == 0);
        g1 = (wwin == 1) || (rwin == 1);
        waddr = (wwin >= 0) ? addrs[wwin] : '0;
        wdata = (wwin >= 0) ? datas[wwin] : '0;
        raddr = (rwin >= 0) ? addrs[rwin] : '0;
        exp_addr_r = (rwin >= 0) ? raddr : last_raddr;

        checks++;
        if (GNT0 !== g0 || GNT1 !== g1) begin
            errors++;
            $display("[TB] FAIL grants: got %b%b, expected %b%b", GNT0, GNT1, g0, g1);
        end
        checks++;
        if (ENABLE_W !== (wwin >= 0) || ADDR_W !== waddr || Q_W !== wdata) begin
            errors++;
            $display("[TB] FAIL write_port: got en=%b addr=%h data=%h, expected en=%b addr=%h data=%h",
                     ENABLE_W, ADDR_W, Q_W, (wwin >= 0), waddr, wdata);
        end
        checks++;
        if (ADDR_R !== exp_addr_r) begin
            errors++;
            $display("[TB] FAIL read_addr: got %h, expected %h", ADDR_R, exp_addr_r);
        end

        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            exp_rv[i] = (rwin == i);
            exp_rd[i] = '0;
        end
        if (rwin >= 0) begin
            exp_rd[rwin] = (wwin >= 0 && waddr == raddr) ? wdata : ref_mem[raddr];
            last_raddr = raddr;
        end
        if (wwin >= 0) ref_mem[waddr] = wdata;
        if (wants_w[0] && wants_w[1]) prio_w = 1 - wwin;
        if (wants_r[0] && wants_r[1]) prio_r = 1 - rwin;
        @(negedge CLK);
    endtask

    task automatic idle_cycle();
        logic g0, g1;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g0, g1);
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 10'h3; WDATA0 = 32'h55;
        REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 10'h9; WDATA1 = 32'h0;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({GNT0, GNT1, RVALID0, RVALID1, ENABLE_W} !== 5'b0 || ADDR_W !== '0 || Q_W !== '0 ||
            ADDR_R !== '0 || RDATA0 !== '0 || RDATA1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got gnt=%b%b rv=%b%b en=%b aw=%h qw=%h ar=%h, expected all zero",
                     GNT0, GNT1, RVALID0, RVALID1, ENABLE_W, ADDR_W, Q_W, ADDR_R);
        end
        RESET = 1'b0;
        idle_cycle();
    endtask

    task automatic test_write_contention();
        logic g0, g1;
        logic [DW-1:0] da = 32'hAAAA_0003;
        logic [DW-1:0] db = 32'hBBBB_0005;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b1, 1'b1, 10'd3, da, 1'b1, 1'b1, 10'd5, db, g0, g1);
        end
        idle_cycle();
        checks++;
        if (ram[3] !== da || ram[5] !== db) begin
            errors++;
            $display("[TB] FAIL contention_ram: got mem3=%h mem5=%h, expected %h %h", ram[3], ram[5], da, db);
        end
    endtask

    task automatic test_read_write_parallel();
        logic g0, g1;
        apply_stimulus(1'b1, 1'b1, 10'd7, 32'h1234, 1'b1, 1'b0, 10'd2, '0, g0, g1);
        idle_cycle();
    endtask

    task automatic test_hazard_bypass();
        logic g0, g1;
        apply_stimulus(1'b1, 1'b1, 10'd4, 32'hCAFE, 1'b1, 1'b0, 10'd4, '0, g0, g1);
        checks++;
        if (RDATA1 !== 32'hCAFE) begin
            errors++;
            $display("[TB] FAIL bypass: got %h, expected %h", RDATA1, 32'hCAFE);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic g0, g1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, g0, g1);
        end
        idle_cycle();
    endtask

    task automatic test_random();
        logic          r [2], w [2], g [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        for (int i = 0; i < 2; i++) begin
            r[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; g[i] = 1'b1;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                // A request that lost arbitration must be held unchanged.
                if (!r[i] || g[i]) begin
                    r[i] = ($urandom_range(0, 3) != 0);
                    w[i] = $urandom_range(0, 1) == 1;
                    a[i] = AW'($urandom_range(0, 7));
                    d[i] = $urandom;
                end
            end
            apply_stimulus(r[0], w[0], a[0], d[0], r[1], w[1], a[1], d[1], g[0], g[1]);
        end
        idle_cycle();
    endtask

    task automatic test_reset_in_flight();
        logic g0, g1;
        if (prio_w == 0) begin
            apply_stimulus(1'b1, 1'b1, 10'd20, 32'h1, 1'b1, 1'b1, 10'd21, 32'h2, g0, g1);
        end
        apply_stimulus(1'b1, 1'b0, 10'd1, '0, 1'b1, 1'b1, 10'd30, 32'h77, g0, g1);
        RESET = 1'b1;
        #1;
        checks++;
        if ({GNT0, GNT1, RVALID0, RVALID1, ENABLE_W} !== 5'b0 || ADDR_W !== '0 || Q_W !== '0 ||
            ADDR_R !== '0 || RDATA0 !== '0 || RDATA1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_in_flight: got gnt=%b%b rv=%b%b en=%b aw=%h qw=%h ar=%h rd0=%h, expected all zero",
                     GNT0, GNT1, RVALID0, RVALID1, ENABLE_W, ADDR_W, Q_W, ADDR_R, RDATA0);
        end
        model_reset();
        REQ0 = 1'b0; REQ1 = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        idle_cycle();
        apply_stimulus(1'b1, 1'b1, 10'd40, 32'hA0, 1'b1, 1'b1, 10'd41, 32'hB1, g0, g1);
        checks++;
        if (g0 !== 1'b1 || g1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_winner: model grants %b%b, required 10", g0, g1);
        end
        idle_cycle();
    endtask

    initial begin
        RESET = 1'b1;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            ram[i]     <= v;
            ref_mem[i]  = v;
        end
        test_reset();
        test_write_contention();
        test_read_write_parallel();
        test_hazard_bypass();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
